// File: rtl/i2c_sequencer.sv
// i2c_sequencer: single-command I2C master (START, STOP, WRITE, READ_ACK, READ_NACK) driving open-drain SCL/SDA.
// Define I2C_STRETCH_EN to let a slave hold SCL low and extend any released-SCL quarter.
module i2c_sequencer #(
   parameter int CLKDIV = 70
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [2:0] cmd,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       ack_rx,
   output logic       scl_o,
   output logic       sda_o,
   input  logic       scl_i,
   input  logic       sda_i
);

   localparam logic [2:0]  CMD_START     = 3'd0;
   localparam logic [2:0]  CMD_STOP      = 3'd1;
   localparam logic [2:0]  CMD_WRITE     = 3'd2;
   localparam logic [2:0]  CMD_READ_ACK  = 3'd3;
   localparam logic [2:0]  CMD_READ_NACK = 3'd4;
   localparam logic [15:0] CNT_LAST      = 16'(CLKDIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BIT,
      S_ACKBIT,
      S_STOP,
      S_NOP
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  cmd_reg, cmd_next;
   logic [7:0]  tx_reg, tx_next;
   logic [7:0]  rx_reg, rx_next;
   logic [7:0]  rdata_reg, rdata_next;
   logic        ack_reg, ack_next;
   logic        done_reg, done_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [1:0]  quarter_reg, quarter_next;
   logic [2:0]  bit_reg, bit_next;
   logic        scl_hold_reg, sda_hold_reg;
   logic [1:0]  sda_sync_reg;
   logic        scl_line, sda_line, bit_val;
   logic        advance, tick;

   assign busy   = (state_reg != S_IDLE);
   assign done   = done_reg;
   assign rdata  = rdata_reg;
   assign ack_rx = ack_reg;
   assign scl_o  = scl_line;
   assign sda_o  = sda_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         sda_sync_reg <= 2'b11;
      end else begin
         sda_sync_reg <= {sda_sync_reg[0], sda_i};
      end
   end

`ifdef I2C_STRETCH_EN
   logic [1:0] scl_sync_reg;
   logic [1:0] scl_age_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_reg <= 2'b11;
         scl_age_reg  <= 2'b11;
      end else begin
         scl_sync_reg <= {scl_sync_reg[0], scl_i};
         scl_age_reg  <= {scl_age_reg[0], scl_line};
      end
   end

   // scl_age_reg delays our own release by the synchroniser depth, so a fresh release is not read as a stretch
   assign advance = !(scl_line && scl_age_reg[1] && !scl_sync_reg[1]);
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign advance    = 1'b1;
`endif

   assign tick = advance && (cnt_reg == CNT_LAST);

   // Bit value placed on SDA during a data or acknowledge bit
   always_comb begin
      bit_val = 1'b1;
      if (state_reg == S_BIT) begin
         bit_val = (cmd_reg == CMD_WRITE) ? tx_reg[bit_reg] : 1'b1;
      end else if (state_reg == S_ACKBIT) begin
         bit_val = (cmd_reg == CMD_READ_ACK) ? 1'b0 : 1'b1;
      end
   end

   // Line levels per quarter; in IDLE the last driven levels are held
   always_comb begin
      scl_line = scl_hold_reg;
      sda_line = sda_hold_reg;
      case (state_reg)
         S_START: begin
            case (quarter_reg)
               2'd0: begin
                  sda_line = 1'b1;
               end
               2'd1: begin
                  scl_line = 1'b1;
                  sda_line = 1'b1;
               end
               2'd2: begin
                  scl_line = 1'b1;
                  sda_line = 1'b0;
               end
               default: begin
                  scl_line = 1'b0;
                  sda_line = 1'b0;
               end
            endcase
         end
         S_BIT, S_ACKBIT: begin
            scl_line = (quarter_reg == 2'd1) || (quarter_reg == 2'd2);
            sda_line = bit_val;
         end
         S_STOP: begin
            case (quarter_reg)
               2'd0: begin
                  scl_line = 1'b0;
                  sda_line = 1'b0;
               end
               2'd1: begin
                  scl_line = 1'b1;
                  sda_line = 1'b0;
               end
               default: begin
                  scl_line = 1'b1;
                  sda_line = 1'b1;
               end
            endcase
         end
         default: begin
            scl_line = scl_hold_reg;
            sda_line = sda_hold_reg;
         end
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      cmd_next     = cmd_reg;
      tx_next      = tx_reg;
      rx_next      = rx_reg;
      rdata_next   = rdata_reg;
      ack_next     = ack_reg;
      done_next    = 1'b0;
      cnt_next     = cnt_reg;
      quarter_next = quarter_reg;
      bit_next     = bit_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next     = 16'd0;
            quarter_next = 2'd0;
            bit_next     = 3'd7;
            if (cmd_valid) begin
               cmd_next = cmd;
               tx_next  = wdata;
               case (cmd)
                  CMD_START:                               state_next = S_START;
                  CMD_STOP:                                state_next = S_STOP;
                  CMD_WRITE, CMD_READ_ACK, CMD_READ_NACK:  state_next = S_BIT;
                  default:                                 state_next = S_NOP;
               endcase
            end
         end
         S_NOP: begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end
         default: begin
            if (advance) begin
               cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;
            end
            if (tick) begin
               quarter_next = quarter_reg + 2'd1;
               // SDA is sampled at the end of the second SCL-high quarter
               if (quarter_reg == 2'd2) begin
                  if (state_reg == S_BIT) begin
                     rx_next = {rx_reg[6:0], sda_sync_reg[1]};
                  end else if (state_reg == S_ACKBIT && cmd_reg == CMD_WRITE) begin
                     ack_next = sda_sync_reg[1];
                  end
               end
               if (quarter_reg == 2'd3) begin
                  case (state_reg)
                     S_BIT: begin
                        if (bit_reg == 3'd0) begin
                           state_next = S_ACKBIT;
                        end else begin
                           bit_next = bit_reg - 3'd1;
                        end
                     end
                     S_ACKBIT: begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                        if (cmd_reg != CMD_WRITE) begin
                           rdata_next = rx_reg;
                        end
                     end
                     default: begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                     end
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         cmd_reg      <= 3'd0;
         tx_reg       <= 8'h00;
         rx_reg       <= 8'h00;
         rdata_reg    <= 8'h00;
         ack_reg      <= 1'b1;
         done_reg     <= 1'b0;
         cnt_reg      <= 16'd0;
         quarter_reg  <= 2'd0;
         bit_reg      <= 3'd7;
         scl_hold_reg <= 1'b1;
         sda_hold_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cmd_reg      <= cmd_next;
         tx_reg       <= tx_next;
         rx_reg       <= rx_next;
         rdata_reg    <= rdata_next;
         ack_reg      <= ack_next;
         done_reg     <= done_next;
         cnt_reg      <= cnt_next;
         quarter_reg  <= quarter_next;
         bit_reg      <= bit_next;
         if (state_reg != S_IDLE) begin
            scl_hold_reg <= scl_line;
            sda_hold_reg <= sda_line;
         end
      end
   end

endmodule

// File: tb/tb_i2c_sequencer.sv
// Directed bench for i2c_sequencer with CLKDIV=4, open-drain pull-up bus and a simple slave model.
module tb_i2c_sequencer;

   localparam int CD = 4;
   localparam logic [2:0] C_START  = 3'd0;
   localparam logic [2:0] C_STOP   = 3'd1;
   localparam logic [2:0] C_WRITE  = 3'd2;
   localparam logic [2:0] C_RDACK  = 3'd3;
   localparam logic [2:0] C_RDNACK = 3'd4;
`ifdef I2C_STRETCH_EN
   localparam int STRETCH_EXP = 164;
`else
   localparam int STRETCH_EXP = 144;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [7:0] wdata;
   logic       busy, done, ack_rx, scl_o, sda_o, scl_i, sda_i;
   logic [7:0] rdata;
   logic       slave_sda, slave_scl;

   int         tests = 0;
   int         fails = 0;
   int         ncyc;
   logic [8:0] seen, seen_dut;
   logic [7:0] qs, mid_rdata;
   logic       pre_scl, pre_sda;
   int         dn;

   assign sda_i = sda_o & slave_sda;
   assign scl_i = scl_o & slave_scl;

   i2c_sequencer #(.CLKDIV(CD)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .ack_rx(ack_rx),
      .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one command, plays the slave, and records bus activity until busy drops.
   task automatic run_cmd(input logic [2:0] c, input logic [7:0] w, input logic [7:0] sbyte,
                          input logic sack, input int stretch_rise, input int abort_at,
                          input bit hold_stop);
      int   n, rises, falls, stretch_left;
      logic prev_scl;
      bit   aborted;
      n = 0; rises = 0; falls = 0; stretch_left = 0; aborted = 0;
      seen = '1; seen_dut = '1; qs = '0; mid_rdata = rdata;
      @(negedge clk);
      cmd = c; wdata = w; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      prev_scl = scl_o;
      while (busy && n < 400) begin
         if (scl_o && !prev_scl) begin
            if (rises < 9) begin
               seen[8-rises]     = sda_i;
               seen_dut[8-rises] = sda_o;
            end
            if (rises == stretch_rise) stretch_left = 20;
            rises++;
         end
         if (!scl_o && prev_scl) falls++;
         prev_scl = scl_o;
         if (stretch_left > 0) begin
            slave_scl = 1'b0;
            stretch_left--;
         end else begin
            slave_scl = 1'b1;
         end
         if (c == C_WRITE) slave_sda = (falls == 8) ? sack : 1'b1;
         else if (c == C_RDACK || c == C_RDNACK) slave_sda = (falls < 8) ? sbyte[7-falls] : 1'b1;
         else slave_sda = 1'b1;
         if (n < 4*CD && (n % CD) == 1) begin
            qs[7-2*(n/CD)] = scl_o;
            qs[6-2*(n/CD)] = sda_o;
         end
         if (n == 100) mid_rdata = rdata;
         if (hold_stop) begin
            cmd       = C_STOP;
            cmd_valid = (n >= 2 && n < 100);
         end
         if (n == abort_at) begin
            pre_scl = scl_o;
            pre_sda = sda_o;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            aborted = 1;
            break;
         end
         @(posedge clk); #1;
         n++;
      end
      slave_sda = 1'b1;
      slave_scl = 1'b1;
      ncyc = n;
      if (!aborted) begin
         check("done_pulse", done, 1);
         $display("[TB] cmd=%0d wdata=%02h busy_cycles=%0d rdata=%02h ack_rx=%0b", c, w, n, rdata, ack_rx);
         @(posedge clk); #1;
         check("done_single", done, 0);
      end else begin
         $display("[TB] cmd=%0d wdata=%02h aborted by reset at busy cycle %0d", c, w, n);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd = 3'd0; wdata = 8'h00;
      slave_sda = 1'b1; slave_scl = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_scl", scl_o, 1);
      check("rst_sda", sda_o, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ack", ack_rx, 1);
      check("rst_rdata", rdata, 8'h00);

      run_cmd(C_START, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("start_len", ncyc, 16);
      check("start_wave", qs, 8'hF8);

      run_cmd(C_WRITE, 8'hA5, 8'hFF, 1'b0, -1, -1, 0);
      check("wr_len", ncyc, 144);
      check("wr_bits", seen[8:1], 8'hA5);
      check("wr_ackbit", seen[0], 0);
      check("wr_ack_rx", ack_rx, 0);

      run_cmd(C_RDNACK, 8'h00, 8'h3C, 1'b1, -1, -1, 0);
      check("rdn_len", ncyc, 144);
      check("rdn_partial", mid_rdata, 8'h00);
      check("rdn_rdata", rdata, 8'h3C);
      check("rdn_release", seen_dut[8:1], 8'hFF);
      check("rdn_acksda", seen_dut[0], 1);
      check("rdn_ack_held", ack_rx, 0);

      run_cmd(C_RDACK, 8'h00, 8'hC3, 1'b1, -1, -1, 0);
      check("rda_len", ncyc, 144);
      check("rda_partial", mid_rdata, 8'h3C);
      check("rda_rdata", rdata, 8'hC3);
      check("rda_acksda", seen_dut[0], 0);

      run_cmd(C_WRITE, 8'h5A, 8'hFF, 1'b1, -1, -1, 1);
      check("hold_len", ncyc, 144);
      check("hold_bits", seen[8:1], 8'h5A);
      check("hold_nack", ack_rx, 1);
      check("hold_not_queued", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_idle_busy", busy, 0);
      check("hold_idle_scl", scl_o, 0);

      run_cmd(C_STOP, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("stop_len", ncyc, 16);
      check("stop_wave", qs, 8'h2F);
      check("stop_idle", {scl_o, sda_o}, 2'b11);

      run_cmd(3'd6, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("nop_len", ncyc, 1);

      run_cmd(C_START, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("start2_wave", qs, 8'hF8);
      run_cmd(C_WRITE, 8'h00, 8'hFF, 1'b0, -1, -1, 0);
      check("wr00_ack", ack_rx, 0);
      run_cmd(C_START, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("rstart_len", ncyc, 16);
      check("rstart_wave", qs, 8'h78);

      run_cmd(C_WRITE, 8'hA5, 8'hFF, 1'b0, -1, 70, 0);
      check("abort_pre_scl", pre_scl, 1);
      check("abort_pre_sda", pre_sda, 0);
      check("abort_scl", scl_o, 1);
      check("abort_sda", sda_o, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ack", ack_rx, 1);
      check("abort_rdata", rdata, 8'h00);
      dn = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      check("abort_no_done", dn, 0);

      run_cmd(C_START, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("start3_wave", qs, 8'hF8);
      run_cmd(C_WRITE, 8'h96, 8'hFF, 1'b0, 2, -1, 0);
      check("stretch_len", ncyc, STRETCH_EXP);
      check("stretch_bits", seen[8:1], 8'h96);
      check("stretch_ack", ack_rx, 0);
      run_cmd(C_STOP, 8'h00, 8'hFF, 1'b1, -1, -1, 0);
      check("stop2_len", ncyc, 16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
